// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-8 sequential multiplier.
// Holds the FSM state enum, default operand widths and digit width.
package mult_pkg;

  localparam int DEF_A_W = 11;
  localparam int DEF_B_W = 12;
  localparam int DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pp_digit_mult.sv
// Combinational A_W x 3-bit partial-product generator.
// Shift-add over the three digit bits; covers all eight digit values.
module pp_digit_mult
  import mult_pkg::*;
#(
  parameter int A_W = DEF_A_W
) (
  input  logic [A_W-1:0]         a,
  input  logic [DIGIT_W-1:0]     d,
  output logic [A_W+DIGIT_W-1:0] pp
);

  logic [A_W+DIGIT_W-1:0] t0;
  logic [A_W+DIGIT_W-1:0] t1;
  logic [A_W+DIGIT_W-1:0] t2;

  // Select a, 2a, 4a per digit bit and sum them
  always_comb begin
    t0 = '0;
    t1 = '0;
    t2 = '0;
    if (d[0]) t0 = {3'b000, a};
    if (d[1]) t1 = {2'b00, a, 1'b0};
    if (d[2]) t2 = {1'b0, a, 2'b00};
    pp = t0 + t1 + t2;
  end

endmodule

// File: rtl/radix8_seq_mult.sv
// Radix-8 sequential unsigned multiplier, one digit per clock.
// Define MULT_EARLY_EXIT_EN to finish once the remaining digits are zero.
module radix8_seq_mult
  import mult_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_W+B_W-1:0] out_p
);

  localparam int DIGITS = B_W / DIGIT_W;
  localparam int P_W    = A_W + B_W;
  localparam int PP_W   = A_W + DIGIT_W;
  localparam int CNT_W  =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (B_W % DIGIT_W != 0) begin : g_bw_chk
    $error("B_W must be a multiple of 3");
  end

  state_t           state;
  logic [A_W-1:0]   a_reg;
  logic [B_W-1:0]   b_sh;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   acc;
  logic [PP_W-1:0]  pp;
  logic [P_W-1:0]   pp_sh;
  logic             last;

  pp_digit_mult #(
    .A_W (A_W)
  ) u_pp (
    .a  (a_reg),
    .d  (b_sh[DIGIT_W-1:0]),
    .pp (pp)
  );

  // Align the zero-extended partial product to its digit weight
  always_comb begin
    pp_sh = P_W'(pp) << (DIGIT_W * int'(cnt));
`ifdef MULT_EARLY_EXIT_EN
    last = ((b_sh >> DIGIT_W) == '0);
`else
    last = (cnt == CNT_W'(DIGITS - 1));
`endif
  end

  // Control FSM and datapath registers with registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      a_reg     <= '0;
      b_sh      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_sh     <= in_b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + pp_sh;
          b_sh <= b_sh >> DIGIT_W;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign out_p = acc;

endmodule
